gemm_tile_writeback: RTL and testbench

//  Downstream of the GeMM accelerator: captures each completed MxN output tile (all elements in parallel)
//  and drains it to output SRAM C as one element write per cycle, row-major, at the tile's matrix position.

---
 rtl/gemm_tile_writeback.sv | 229 ++++++++++++++++++++++
 tb/tb_gemm_tile_writeback.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_tile_writeback.sv
// gemm_tile_writeback: two-slot (ping-pong) buffer of completed MxN GeMM tiles,
// drained to SRAM C one element per cycle in row-major order. Elements that fall
// outside the matrix (edge tiles) are skipped without a write, and the SRAM grant
// stalls the drain.
module gemm_tile_writeback #(
    parameter int OutDataWidth  = 32,
    parameter int AddrWidth     = 16,
    parameter int SizeAddrWidth = 8,
    parameter int M             = 4,
    parameter int N             = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           tile_valid_i,
    output logic                           tile_ready_o,
    input  logic signed [OutDataWidth-1:0] tile_data_i [0:M*N-1],
    input  logic [SizeAddrWidth-1:0]       tile_m_i,
    input  logic [SizeAddrWidth-1:0]       tile_n_i,
    input  logic [SizeAddrWidth-1:0]       M_size_i,
    input  logic [SizeAddrWidth-1:0]       N_size_i,
    output logic [AddrWidth-1:0]           sram_c_addr_o,
    output logic signed [OutDataWidth-1:0] sram_c_wdata_o,
    output logic                           sram_c_we_o,
    input  logic                           sram_c_gnt_i,
    output logic                           tile_done_o,
    output logic                           busy_o
);

    localparam int NE = M * N;
    localparam int IW = (NE > 1) ? $clog2(NE) : 1;
    localparam int SW = SizeAddrWidth;
    localparam int RW = SizeAddrWidth + 1;
    localparam int AW = AddrWidth;
    localparam int OW = OutDataWidth;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Bounds check is done one bit wider than the origin fields so that
    // origin + offset can never wrap back into range.
    function automatic logic elem_in_bounds(
        input logic [SW-1:0] tm,
        input logic [SW-1:0] tn,
        input logic [IW-1:0] idx,
        input logic [SW-1:0] msz,
        input logic [SW-1:0] nsz
    );
        logic [RW-1:0] row;
        logic [RW-1:0] col;
        row = {1'b0, tm} + RW'(int'(idx) / N);
        col = {1'b0, tn} + RW'(int'(idx) % N);
        return (row < {1'b0, msz}) && (col < {1'b0, nsz});
    endfunction

    // Row-major address of the element, truncated to the SRAM address width.
    function automatic logic [AW-1:0] elem_addr(
        input logic [SW-1:0] tm,
        input logic [SW-1:0] tn,
        input logic [IW-1:0] idx,
        input logic [SW-1:0] nsz
    );
        logic [RW-1:0] row;
        logic [RW-1:0] col;
        row = {1'b0, tm} + RW'(int'(idx) / N);
        col = {1'b0, tn} + RW'(int'(idx) % N);
        return AW'(row) * AW'(nsz) + AW'(col);
    endfunction

    state_t              state_r, state_n;
    logic [1:0]          count_r, count_n;
    logic                wr_ptr_r;
    logic                rd_ptr_r;
    logic [IW-1:0]       e_r, e_n;
    logic                we_r, we_n;
    logic [AW-1:0]       addr_r, addr_n;
    logic signed [OW-1:0] wdata_r, wdata_n;
    logic                done_r;

    logic signed [OW-1:0] slot_data_r [0:1][0:NE-1];
    logic [SW-1:0]        slot_m_r [0:1];
    logic [SW-1:0]        slot_n_r [0:1];

    logic                accept_s;
    logic                retire_s;
    logic                last_s;
    logic [IW-1:0]       nxt_idx_s;
    logic                from_slot_s;
    logic [SW-1:0]       new_m_s;
    logic [SW-1:0]       new_n_s;
    logic signed [OW-1:0] new_elem_s;
    logic signed [OW-1:0] nxt_elem_s;

    assign tile_ready_o   = (count_r < 2'd2);
    assign busy_o         = (count_r != 2'd0);
    assign sram_c_we_o    = we_r;
    assign sram_c_addr_o  = addr_r;
    assign sram_c_wdata_o = wdata_r;
    assign tile_done_o    = done_r;

    assign accept_s  = tile_valid_i && tile_ready_o;
    // An element retires on a granted write or on its single out-of-bounds cycle.
    assign retire_s  = (state_r == DRAIN) && (!we_r || sram_c_gnt_i);
    assign last_s    = retire_s && (e_r == IW'(NE - 1));
    assign nxt_idx_s = e_r + IW'(1);
    assign nxt_elem_s = slot_data_r[rd_ptr_r][nxt_idx_s];

    // Next tile to start: the other buffered slot if both are full, otherwise the
    // tile arriving this cycle (bypass so the first element has one-cycle latency).
    assign from_slot_s = (count_r == 2'd2);
    assign new_m_s     = from_slot_s ? slot_m_r[!rd_ptr_r] : tile_m_i;
    assign new_n_s     = from_slot_s ? slot_n_r[!rd_ptr_r] : tile_n_i;
    assign new_elem_s  = from_slot_s ? slot_data_r[!rd_ptr_r][0] : tile_data_i[0];

    // Occupancy: accept increments, retiring the last element of a tile frees a slot.
    always_comb begin
        count_n = count_r;
        case ({accept_s, last_s})
            2'b10:   count_n = count_r + 2'd1;
            2'b01:   count_n = count_r - 2'd1;
            default: count_n = count_r;
        endcase
    end

    // Drain FSM next state and next registered write-port values.
    always_comb begin
        state_n = state_r;
        e_n     = e_r;
        we_n    = we_r;
        addr_n  = addr_r;
        wdata_n = wdata_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_n = DRAIN;
                    e_n     = '0;
                    we_n    = elem_in_bounds(new_m_s, new_n_s, '0, M_size_i, N_size_i);
                    addr_n  = elem_addr(new_m_s, new_n_s, '0, N_size_i);
                    wdata_n = new_elem_s;
                end else begin
                    we_n = 1'b0;
                end
            end
            DRAIN: begin
                if (last_s) begin
                    e_n = '0;
                    if (from_slot_s || accept_s) begin
                        we_n    = elem_in_bounds(new_m_s, new_n_s, '0, M_size_i, N_size_i);
                        addr_n  = elem_addr(new_m_s, new_n_s, '0, N_size_i);
                        wdata_n = new_elem_s;
                    end else begin
                        state_n = IDLE;
                        we_n    = 1'b0;
                    end
                end else if (retire_s) begin
                    e_n     = nxt_idx_s;
                    we_n    = elem_in_bounds(slot_m_r[rd_ptr_r], slot_n_r[rd_ptr_r],
                                             nxt_idx_s, M_size_i, N_size_i);
                    addr_n  = elem_addr(slot_m_r[rd_ptr_r], slot_n_r[rd_ptr_r],
                                        nxt_idx_s, N_size_i);
                    wdata_n = nxt_elem_s;
                end else begin
                    e_n = e_r;
                end
            end
            default: begin
                state_n = IDLE;
                we_n    = 1'b0;
            end
        endcase
    end

    // FSM state, element index and registered SRAM write port.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= IDLE;
            e_r     <= '0;
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            e_r     <= e_n;
            we_r    <= we_n;
            addr_r  <= addr_n;
            wdata_r <= wdata_n;
            done_r  <= last_s;
        end
    end

    // Slot occupancy count and ping-pong pointers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_r  <= 2'd0;
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
        end else begin
            count_r <= count_n;
            if (accept_s) begin
                wr_ptr_r <= !wr_ptr_r;
            end
            if (last_s) begin
                rd_ptr_r <= !rd_ptr_r;
            end
        end
    end

    // Tile storage: capture data and origin into the write-pointer slot.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < 2; s++) begin
                slot_m_r[s] <= '0;
                slot_n_r[s] <= '0;
                for (int k = 0; k < NE; k++) begin
                    slot_data_r[s][k] <= '0;
                end
            end
        end else if (accept_s) begin
            slot_m_r[wr_ptr_r] <= tile_m_i;
            slot_n_r[wr_ptr_r] <= tile_n_i;
            for (int k = 0; k < NE; k++) begin
                slot_data_r[wr_ptr_r][k] <= tile_data_i[k];
            end
        end
    end

endmodule

// File: tb/tb_gemm_tile_writeback.sv
// Directed bench for gemm_tile_writeback with a write scoreboard.
module tb_gemm_tile_writeback;

    localparam int OW = 32;
    localparam int AW = 16;
    localparam int SW = 8;
    localparam int M  = 4;
    localparam int N  = 4;
    localparam int NE = M * N;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [OW-1:0] d;
    } wr_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 valid = 1'b0;
    logic                 ready;
    logic signed [OW-1:0] td [0:NE-1];
    logic [SW-1:0]        tm = '0;
    logic [SW-1:0]        tn = '0;
    logic [SW-1:0]        msz = 8'd8;
    logic [SW-1:0]        nsz = 8'd8;
    logic [AW-1:0]        addr;
    logic signed [OW-1:0] wdata;
    logic                 we;
    logic                 gnt = 1'b1;
    logic                 done;
    logic                 busy;

    wr_t  exp_q [$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   writes_seen = 0;
    int   done_cnt = 0;
    int   first_cyc = -1;
    int   last_cyc = 0;
    logic hold_pending = 1'b0;
    logic [AW-1:0] held_a;
    logic [OW-1:0] held_d;
    int   gnt_mode = 0;
    int   gphase = 0;
    int   k;

    gemm_tile_writeback #(
        .OutDataWidth(OW), .AddrWidth(AW), .SizeAddrWidth(SW), .M(M), .N(N)
    ) dut (
        .clk_i(clk), .rst_i(rst), .tile_valid_i(valid), .tile_ready_o(ready),
        .tile_data_i(td), .tile_m_i(tm), .tile_n_i(tn), .M_size_i(msz), .N_size_i(nsz),
        .sram_c_addr_o(addr), .sram_c_wdata_o(wdata), .sram_c_we_o(we),
        .sram_c_gnt_i(gnt), .tile_done_o(done), .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Grant pattern: constant 1, or repeating 1,0,0.
    always @(posedge clk) begin
        #1;
        if (gnt_mode == 0) begin
            gnt = 1'b1;
        end else begin
            gnt = (gphase == 0);
            gphase = (gphase + 1) % 3;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Monitor: scoreboard pop on granted writes, hold check on stalls, done count.
    always @(negedge clk) begin
        if (rst) begin
            hold_pending = 1'b0;
        end else begin
            if (done) done_cnt++;
            if (hold_pending) begin
                chk("stall_we_held", {63'd0, we}, 64'd1);
                chk("stall_addr_held", {48'd0, addr}, {48'd0, held_a});
                chk("stall_data_held", {32'd0, wdata}, {32'd0, held_d});
            end
            hold_pending = we && !gnt;
            held_a = addr;
            held_d = wdata;
            if (we && gnt) begin
                wr_t e;
                chk("write_expected", {63'd0, (exp_q.size() != 0)}, 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("write_addr", {48'd0, addr}, {48'd0, e.a});
                    chk("write_data", {32'd0, wdata}, {32'd0, e.d});
                end
                writes_seen++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
        end
    end

    task automatic clear_stats();
        writes_seen = 0;
        done_cnt = 0;
        first_cyc = -1;
        last_cyc = 0;
    endtask

    // Present one tile (waiting for ready within a bound) and push its expected writes.
    task automatic send(input logic [SW-1:0] m0, input logic [SW-1:0] n0,
                        input int base, input bit neg);
        int w = 0;
        while (!ready && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        chk("ready_wait_bound", {63'd0, ready}, 64'd1);
        tm = m0;
        tn = n0;
        for (int e = 0; e < NE; e++) begin
            if (neg) td[e] = (e % 2 == 0) ? 32'hFFFF_FFFF : (32'h8000_0000 | e);
            else     td[e] = base + e;
        end
        for (int e = 0; e < NE; e++) begin
            int r = e / N;
            int c = e % N;
            int row = int'(m0) + r;
            int col = int'(n0) + c;
            if (row < int'(msz) && col < int'(nsz)) begin
                wr_t x;
                x.a = AW'(row * int'(nsz) + col);
                x.d = td[e];
                exp_q.push_back(x);
            end
        end
        valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w = 0;
        while ((busy || exp_q.size() != 0) && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("drain_bound", {63'd0, busy}, 64'd0);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        for (int e = 0; e < NE; e++) td[e] = '0;
        #12;
        chk("rst_ready", {63'd0, ready}, 64'd1);
        chk("rst_we", {63'd0, we}, 64'd0);
        chk("rst_addr", {48'd0, addr}, 64'd0);
        chk("rst_wdata", {32'd0, wdata}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: single in-bounds tile at (0,4) in an 8x8 matrix
        clear_stats();
        send(8'd0, 8'd4, 32'h100, 1'b0);
        chk("t1_first_present_we", {63'd0, we}, 64'd1);
        chk("t1_first_addr", {48'd0, addr}, 64'd4);
        wait_drain();
        chk("t1_writes", 64'(writes_seen), 64'd16);
        chk("t1_span", 64'(last_cyc - first_cyc), 64'd15);
        chk("t1_done_cnt", 64'(done_cnt), 64'd1);

        // 2: back-to-back tiles, third refused until first finishes
        clear_stats();
        send(8'd0, 8'd0, 32'h200, 1'b0);
        send(8'd4, 8'd0, 32'h300, 1'b0);
        chk("t2_ready_full", {63'd0, ready}, 64'd0);
        chk("t2_busy", {63'd0, busy}, 64'd1);
        send(8'd4, 8'd4, 32'h400, 1'b0);
        wait_drain();
        chk("t2_writes", 64'(writes_seen), 64'd48);
        chk("t2_span_no_bubble", 64'(last_cyc - first_cyc), 64'd47);
        chk("t2_done_cnt", 64'(done_cnt), 64'd3);

        // 3: grant toggling 1,0,0
        clear_stats();
        gnt_mode = 1;
        send(8'd4, 8'd0, 32'h500, 1'b0);
        wait_drain();
        gnt_mode = 0;
        chk("t3_writes", 64'(writes_seen), 64'd16);
        chk("t3_done_cnt", 64'(done_cnt), 64'd1);

        // 4: edge tile, 6x6 matrix, origin (4,4)
        clear_stats();
        msz = 8'd6;
        nsz = 8'd6;
        chk("t4_model_count", 64'(exp_q.size()), 64'd0);
        send(8'd4, 8'd4, 32'h600, 1'b0);
        chk("t4_model_entries", 64'(exp_q.size()), 64'd4);
        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("t4_drain_cycles", 64'(k), 64'(NE + 1));
        wait_drain();
        chk("t4_writes", 64'(writes_seen), 64'd4);

        // Zero-size matrix: no writes, full-length drain
        clear_stats();
        msz = 8'd0;
        nsz = 8'd0;
        send(8'd0, 8'd0, 32'h700, 1'b0);
        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("t4z_drain_cycles", 64'(k), 64'(NE + 1));
        wait_drain();
        chk("t4z_writes", 64'(writes_seen), 64'd0);

        // 5: reset on the 5th write, then a fresh tile
        clear_stats();
        msz = 8'd8;
        nsz = 8'd8;
        send(8'd0, 8'd0, 32'h800, 1'b0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("t5_we_at_5th", {63'd0, we}, 64'd1);
        chk("t5_addr_at_5th", {48'd0, addr}, 64'd8);
        chk("t5_writes_before", 64'(writes_seen), 64'd4);
        rst = 1'b1;
        #1;
        chk("t5_rst_we", {63'd0, we}, 64'd0);
        chk("t5_rst_ready", {63'd0, ready}, 64'd1);
        chk("t5_rst_busy", {63'd0, busy}, 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("t5_idle_we", {63'd0, we}, 64'd0);
        clear_stats();
        send(8'd0, 8'd0, 32'h900, 1'b0);
        chk("t5_restart_addr", {48'd0, addr}, 64'd0);
        wait_drain();
        chk("t5_writes", 64'(writes_seen), 64'd16);

        // 6: negative data written bit-exact
        clear_stats();
        send(8'd0, 8'd0, 0, 1'b1);
        chk("t6_first_data", {32'd0, wdata}, 64'hFFFF_FFFF);
        wait_drain();
        chk("t6_writes", 64'(writes_seen), 64'd16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
